// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, the response-stage record and
// the byte-lane merge used for masked writes.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    // One slot of the response pipeline.
    typedef struct packed {
        logic                 valid;
        logic                 is_err;
        logic [WB_DATA_W-1:0] rdata;
    } wb_stage_t;

    // Replace only the byte lanes whose select bit is set; sel[0] is data[7:0].
    function automatic logic [WB_DATA_W-1:0] wb_byte_merge(
        input logic [WB_DATA_W-1:0] old_word,
        input logic [WB_DATA_W-1:0] new_word,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (sel[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-length response pipeline. An entry enters stage 0 on the
// acceptance edge and is presented at the last stage LATENCY cycles later.
// A flush (bus cycle abort) drops every in-flight entry.
module wb_resp_pipe
    import wb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  wb_stage_t stage_i,
    output wb_stage_t stage_o
);

    localparam wb_stage_t STAGE_IDLE = '{1'b0, 1'b0, 32'h0000_0000};

    wb_stage_t stage_q [LATENCY];
    wb_stage_t stage_d [LATENCY];

    // Next state: shift one slot toward the output, or empty the pipe on flush
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            stage_d[i] = STAGE_IDLE;
        end
        if (flush_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_d[i] = STAGE_IDLE;
            end
        end else begin
            stage_d[0] = stage_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers; reset invalidates every slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= STAGE_IDLE;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign stage_o = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_pipelined_mem_responder.sv
// Pipelined Wishbone responder memory. Requests are classified, written or
// read in the acceptance cycle; the result travels through wb_resp_pipe and
// is answered with ack or err a fixed number of cycles later. An outstanding
// counter throttles the initiator through wb_stall_o.
module wb_pipelined_mem_responder
    import wb_pkg::*;
#(
    parameter int    MEM_WORDS       = 1024,
    parameter int    LATENCY         = 2,
    parameter int    MAX_OUTSTANDING = 4,
    parameter string INIT_FILE       = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] wb_data_o
);

    localparam int               IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int               CNT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [29:0]      WORDS_LIMIT = 30'(MEM_WORDS);

    logic [WB_DATA_W-1:0] mem_q [MEM_WORDS];
    logic [CNT_W-1:0]     outstanding_q;
    logic [CNT_W-1:0]     outstanding_d;

    logic                 accept_s;
    logic                 addr_err_s;
    logic [IDX_W-1:0]     word_idx_s;
    logic                 resp_fire_s;
    wb_stage_t            req_stage_s;
    wb_stage_t            rsp_stage_s;

    assign word_idx_s  = wb_addr_i[IDX_W+1:2];
    assign wb_stall_o  = (outstanding_q >= CNT_MAX);
    assign resp_fire_s = rsp_stage_s.valid;

    // Classify the request and decide whether it is accepted this edge
    always_comb begin
        addr_err_s = (wb_addr_i[1:0] != 2'b00) || (wb_addr_i[31:2] >= WORDS_LIMIT);
        accept_s   = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~rst;
    end

    // Build the response entry; reads capture the array word now, writes and
    // errored requests carry zero data
    always_comb begin
        req_stage_s.valid  = accept_s;
        req_stage_s.is_err = addr_err_s;
        req_stage_s.rdata  = 32'h0000_0000;
        if (accept_s && !addr_err_s && !wb_we_i) begin
            req_stage_s.rdata = mem_q[word_idx_s];
        end else begin
            req_stage_s.rdata = 32'h0000_0000;
        end
    end

    // Byte-masked write in the acceptance cycle; errored writes are discarded
    always_ff @(posedge clk) begin
        if (accept_s && wb_we_i && !addr_err_s) begin
            mem_q[word_idx_s] <= wb_byte_merge(mem_q[word_idx_s], wb_data_i, wb_sel_i);
        end
    end

    // Outstanding count: +1 per accept, -1 per response, cleared on abort
    always_comb begin
        outstanding_d = outstanding_q;
        if (!wb_cyc_i) begin
            outstanding_d = {CNT_W{1'b0}};
        end else if (accept_s && !resp_fire_s) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!accept_s && resp_fire_s) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Outstanding counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= {CNT_W{1'b0}};
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    wb_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (~wb_cyc_i),
        .stage_i (req_stage_s),
        .stage_o (rsp_stage_s)
    );

    assign wb_ack_o  = rsp_stage_s.valid & ~rsp_stage_s.is_err;
    assign wb_err_o  = rsp_stage_s.valid &  rsp_stage_s.is_err;
    assign wb_data_o = wb_ack_o ? rsp_stage_s.rdata : 32'h0000_0000;

endmodule
